// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
//   Shared constants and helpers for the debouncer bank.
//
//   Contents:
//     DEF_*              default parameter values for debouncer_bank
//     MAX_CHANNELS       largest supported channel count
//     MAX_STABLE_SAMPLES largest supported stability threshold
//     stab_action_e      what a channel's stability logic does this cycle
//     stab_action()      decodes tick / mismatch / threshold into an action
//
//   Optional feature macro used by the bank: DEBOUNCER_BANK_SYNC_EN
// -----------------------------------------------------------------------------
package debouncer_pkg;

    localparam int unsigned DEF_CHANNELS       = 4;
    localparam int unsigned DEF_TICK_DIV       = 2097152;
    localparam int unsigned DEF_STABLE_SAMPLES = 3;
    localparam logic        DEF_RESET_LEVEL    = 1'b0;

    localparam int unsigned MAX_CHANNELS       = 32;
    localparam int unsigned MAX_STABLE_SAMPLES = 255;

    typedef enum logic [1:0] {
        STAB_HOLD   = 2'd0,  // not a sample tick: keep everything
        STAB_CLEAR  = 2'd1,  // sample agrees with level: forget partial run
        STAB_COUNT  = 2'd2,  // sample differs, threshold not yet reached
        STAB_ACCEPT = 2'd3   // sample differs on the last required tick
    } stab_action_e;

    function automatic stab_action_e stab_action(input logic tick,
                                                 input logic differs,
                                                 input logic at_last);
        stab_action_e act;
        if (!tick)
            act = STAB_HOLD;
        else if (!differs)
            act = STAB_CLEAR;
        else if (at_last)
            act = STAB_ACCEPT;
        else
            act = STAB_COUNT;
        return act;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One debounced input: optional two-flop synchronizer, stability counter,
//   registered level and registered rise/fall edge pulses.
//
//   Ports:
//     clock  in   clock, all state on posedge
//     rst_n  in   asynchronous active-low reset
//     tick   in   shared sample strobe from the bank prescaler
//     raw    in   bouncy input bit
//     level  out  debounced level (reset value RESET_LEVEL)
//     rise   out  one-cycle pulse coincident with level going 0->1
//     fall   out  one-cycle pulse coincident with level going 1->0
//
//   Macro DEBOUNCER_BANK_SYNC_EN: when defined, raw passes through two flops
//   (reset to RESET_LEVEL) before being sampled.
// -----------------------------------------------------------------------------
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter logic        RESET_LEVEL    = DEF_RESET_LEVEL
) (
    input  logic clock,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

    logic          sample;
    logic [CW-1:0] stab_cnt;
    stab_action_e  action;

`ifdef DEBOUNCER_BANK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            sync_q <= {2{RESET_LEVEL}};
        else
            sync_q <= {sync_q[0], raw};
    end

    assign sample = sync_q[1];
`else
    assign sample = raw;
`endif

    always_comb begin
        action = stab_action(tick, sample != level, stab_cnt == LAST);
    end

    // Edge pulses are registered alongside level so they line up with the
    // new level value rather than preceding it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
            level    <= RESET_LEVEL;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (action)
                STAB_CLEAR: stab_cnt <= '0;
                STAB_COUNT: stab_cnt <= stab_cnt + CW'(1);
                STAB_ACCEPT: begin
                    stab_cnt <= '0;
                    level    <= sample;
                    rise     <= sample;
                    fall     <= ~sample;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/debouncer_bank.sv
// -----------------------------------------------------------------------------
// debouncer_bank
//   A bank of CHANNELS independent debouncers sharing one sample prescaler.
//
//   Parameters:
//     CHANNELS        number of debounced inputs (1..32)
//     TICK_DIV        clock cycles per sample tick (>=2)
//     STABLE_SAMPLES  consecutive differing samples to accept a level (1..255)
//     RESET_LEVEL     value of every level bit after reset
//
//   Ports:
//     clock  in   clock, all state on posedge
//     rst_n  in   asynchronous active-low reset
//     raw    in   [CHANNELS] bouncy inputs
//     level  out  [CHANNELS] debounced levels
//     rise   out  [CHANNELS] one-cycle 0->1 pulses
//     fall   out  [CHANNELS] one-cycle 1->0 pulses
//     tick   out  one-cycle sample strobe
//
//   Macro DEBOUNCER_BANK_SYNC_EN: adds a two-flop synchronizer per channel.
// -----------------------------------------------------------------------------
module debouncer_bank
    import debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS       = DEF_CHANNELS,
    parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter logic        RESET_LEVEL    = DEF_RESET_LEVEL
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESCALE_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescale;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            prescale <= '0;
        else if (prescale == PRESCALE_TOP)
            prescale <= '0;
        else
            prescale <= prescale + PW'(1);
    end

    // Decoded from the count, so it is low while reset holds the count at 0.
    assign tick = (prescale == PRESCALE_TOP);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_ch (
            .clock (clock),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (raw[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debouncer_bank.sv
module tb_debouncer_bank;

    localparam int unsigned CHANNELS = 4;
`ifdef DEBOUNCER_BANK_SYNC_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic                clock;
    logic                rst_n;
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                tick;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    debouncer_bank #(
        .CHANNELS       (CHANNELS),
        .TICK_DIV       (4),
        .STABLE_SAMPLES (3),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .raw   (raw),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .tick  (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the active edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Step at least once, stopping in the next cycle where tick is high.
    task automatic wait_tick(output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (!tick && steps < 16);
        if (!tick)
            check("tick_timeout", {31'b0, tick}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_rise",  rise,  0);
        check("rst_fall",  fall,  0);
        check("rst_tick",  tick,  0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        raw   = '0;
        rst_n = 1'b0;
        step();
        do_reset();

        // Tick cadence after release: high on the 3rd, 7th, 11th edge.
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("tick_k%0d", k), tick, (k % 4 == 3) ? 1 : 0);
        end
        check("idle_level", level, 0);
        check("idle_edges", rise | fall, 0);

        // Channel 0: a held high accepted on the third tick.
        raw = 4'b0001;
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("c0_pre_level", level, 4'b0000);
        step();
        check("c0_level", level, 4'b0001);
        check("c0_rise",  rise,  4'b0001);
        check("c0_fall",  fall,  4'b0000);
        step();
        check("c0_rise_end", rise, 4'b0000);

        // Channel 1: two-tick glitch rejected, then three-tick high accepted.
        raw = 4'b0011;
        wait_tick(n);
        wait_tick(n);
        step();
        raw = 4'b0001;
        check("glitch_level", level, 4'b0001);
        check("glitch_rise",  rise,  4'b0000);
        wait_tick(n);
        wait_tick(n);
        step();
        check("glitch_level2", level, 4'b0001);
        check("glitch_edges",  rise | fall, 4'b0000);
        raw = 4'b0011;
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        step();
        check("c1_level", level, 4'b0011);
        check("c1_rise",  rise,  4'b0010);

        // All channels together, rising then falling.
        raw = '0;
        do_reset();
        raw = 4'b1111;
        wait_tick(n);
        check("first_tick_delay", n, 3);
        wait_tick(n);
        wait_tick(n);
        check("all_pre_level", level, 4'b0000);
        step();
        check("all_level", level, 4'b1111);
        check("all_rise",  rise,  4'b1111);
        check("all_fall0", fall,  4'b0000);
        raw = 4'b0000;
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("all_hold", level, 4'b1111);
        step();
        check("all_fall",  fall,  4'b1111);
        check("all_rise0", rise,  4'b0000);
        check("all_low",   level, 4'b0000);

        // Reset in the middle of a partial run discards it.
        raw = 4'b1000;
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        step();
        check("c3_level", level, 4'b1000);
        step();
        raw = 4'b1100;
        wait_tick(n);
        wait_tick(n);
        step();
        step();
        do_reset();
        wait_tick(n);
        check("rel_tick_delay", n, 3);
        check("rel_no_fall", fall, 4'b0000);
        wait_tick(n);
        wait_tick(n);
        check("rel_pre_level", level, 4'b0000);
        step();
        check("rel_level", level, 4'b1100);
        check("rel_rise",  rise,  4'b1100);
        check("rel_fall",  fall,  4'b0000);

        // Change one cycle before a tick: the synchronized build sees it a
        // tick later.
        raw = '0;
        do_reset();
        step();
        step();
        raw = 4'b0001;
        for (int i = 0; i < 3 + EXTRA; i++)
            wait_tick(n);
        check("late_pre_level", level, 4'b0000);
        step();
        check("late_level", level, 4'b0001);
        check("late_rise",  rise,  4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
